// File: rtl/oram_client_arbiter.sv
// Multi-client front end for the ORAM core: round-robin command arbitration,
// write-data steering to the granted client, and in-order read data return.
module oram_client_arbiter #(
    parameter int unsigned NumClients = 4,
    parameter int unsigned ORAMU      = 32,
    parameter int unsigned ORAMB      = 512,
    parameter int unsigned FEDWidth   = 64,
    parameter int unsigned BECMDWidth = 2,
    parameter int unsigned TagDepth   = 8
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic [NumClients*BECMDWidth-1:0] ClientCmd,
    input  logic [NumClients*ORAMU-1:0]      ClientPAddr,
    input  logic [NumClients-1:0]            ClientCmdValid,
    output logic [NumClients-1:0]            ClientCmdReady,
    input  logic [NumClients*FEDWidth-1:0]   ClientDataIn,
    input  logic [NumClients-1:0]            ClientDataInValid,
    output logic [NumClients-1:0]            ClientDataInReady,
    output logic [FEDWidth-1:0]              ClientDataOut,
    output logic [NumClients-1:0]            ClientDataOutValid,
    input  logic [NumClients-1:0]            ClientDataOutReady,
    output logic [BECMDWidth-1:0]            ORAMCmd,
    output logic [ORAMU-1:0]                 ORAMPAddr,
    output logic                             ORAMCmdValid,
    input  logic                             ORAMCmdReady,
    output logic [FEDWidth-1:0]              ORAMDataIn,
    output logic                             ORAMDataInValid,
    input  logic                             ORAMDataInReady,
    input  logic [FEDWidth-1:0]              ORAMDataOut,
    input  logic                             ORAMDataOutValid,
    output logic                             ORAMDataOutReady,
    output logic                             ErrorOrphanData
);

    localparam int unsigned BlockChunks = ORAMB / FEDWidth;
    localparam int unsigned IdW   = (NumClients > 1) ? $clog2(NumClients) : 1;
    localparam int unsigned BeatW = (BlockChunks > 1) ? $clog2(BlockChunks) : 1;
    localparam int unsigned PtrW  = (TagDepth > 1) ? $clog2(TagDepth) : 1;
    localparam int unsigned CntW  = $clog2(TagDepth + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WDATA = 1'b1;

    function automatic logic is_read(input logic [BECMDWidth-1:0] c);
        return (c == BECMDWidth'(2)) || (c == BECMDWidth'(3));
    endfunction

    logic [0:0]            state, state_nxt;
    logic [IdW-1:0]        rr_ptr;
    logic [IdW-1:0]        wr_owner, wr_owner_nxt;
    logic [BeatW-1:0]      wr_beat, wr_beat_nxt;
    logic [BeatW-1:0]      rd_beat;
    logic [IdW-1:0]        tag_mem [TagDepth];
    logic [PtrW-1:0]       tag_wr_ptr, tag_rd_ptr;
    logic [CntW-1:0]       tag_cnt;
    logic                  fifo_full, fifo_empty;
    logic [IdW-1:0]        head;

    logic [BECMDWidth-1:0] cmd_arr  [NumClients];
    logic [ORAMU-1:0]      addr_arr [NumClients];
    logic [FEDWidth-1:0]   din_arr  [NumClients];
    logic [NumClients-1:0] eligible;
    logic [IdW-1:0]        grant, rr_next;
    logic                  grant_found;
    int unsigned           cand;
    logic                  cmd_hs, wr_hs, rd_hs, rd_last, tag_push, tag_pop;

    assign fifo_full  = (tag_cnt == CntW'(TagDepth));
    assign fifo_empty = (tag_cnt == '0);
    assign head       = tag_mem[tag_rd_ptr];

    // Unpack client buses and qualify eligibility
    always_comb begin
        for (int i = 0; i < NumClients; i++) begin
            cmd_arr[i]  = ClientCmd[i*BECMDWidth +: BECMDWidth];
            addr_arr[i] = ClientPAddr[i*ORAMU +: ORAMU];
            din_arr[i]  = ClientDataIn[i*FEDWidth +: FEDWidth];
            eligible[i] = ClientCmdValid[i] & (~is_read(cmd_arr[i]) | ~fifo_full);
        end
    end

    // Round-robin search starting at rr_ptr
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        cand        = 0;
        for (int unsigned off = 0; off < NumClients; off++) begin
            cand = int'(rr_ptr) + off;
            if (cand >= NumClients) cand = cand - NumClients;
            if (!grant_found && eligible[IdW'(cand)]) begin
                grant_found = 1'b1;
                grant       = IdW'(cand);
            end
        end
    end

    assign rr_next = (grant == IdW'(NumClients - 1)) ? '0 : IdW'(grant + 1'b1);

    // Command path
    always_comb begin
        ORAMCmd        = cmd_arr[grant];
        ORAMPAddr      = addr_arr[grant];
        ORAMCmdValid   = 1'b0;
        ClientCmdReady = '0;
        if (!Reset && state == ST_IDLE && grant_found) begin
            ORAMCmdValid          = 1'b1;
            ClientCmdReady[grant] = ORAMCmdReady;
        end
    end

    // Write data path, locked to the owner of the write command
    always_comb begin
        ORAMDataIn        = din_arr[wr_owner];
        ORAMDataInValid   = 1'b0;
        ClientDataInReady = '0;
        if (!Reset && state == ST_WDATA) begin
            ORAMDataInValid             = ClientDataInValid[wr_owner];
            ClientDataInReady[wr_owner] = ORAMDataInReady;
        end
    end

    // Read return path, routed by the oldest outstanding tag
    always_comb begin
        ClientDataOut      = ORAMDataOut;
        ClientDataOutValid = '0;
        ORAMDataOutReady   = 1'b0;
        if (!Reset && !fifo_empty) begin
            ClientDataOutValid[head] = ORAMDataOutValid;
            ORAMDataOutReady         = ClientDataOutReady[head];
        end
    end

    assign cmd_hs   = ORAMCmdValid & ORAMCmdReady;
    assign wr_hs    = ORAMDataInValid & ORAMDataInReady;
    assign rd_hs    = ORAMDataOutValid & ORAMDataOutReady;
    assign rd_last  = rd_hs && (rd_beat == BeatW'(BlockChunks - 1));
    assign tag_push = cmd_hs & is_read(ORAMCmd);
    assign tag_pop  = rd_last;

    // Arbiter FSM next state
    always_comb begin
        state_nxt    = state;
        wr_owner_nxt = wr_owner;
        wr_beat_nxt  = wr_beat;
        case (state)
            ST_IDLE: begin
                if (cmd_hs && !is_read(ORAMCmd)) begin
                    state_nxt    = ST_WDATA;
                    wr_owner_nxt = grant;
                    wr_beat_nxt  = '0;
                end
            end
            ST_WDATA: begin
                if (wr_hs) begin
                    wr_beat_nxt = BeatW'(wr_beat + 1'b1);
                    if (wr_beat == BeatW'(BlockChunks - 1)) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            wr_owner        <= '0;
            wr_beat         <= '0;
            rd_beat         <= '0;
            tag_wr_ptr      <= '0;
            tag_rd_ptr      <= '0;
            tag_cnt         <= '0;
            ErrorOrphanData <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_owner <= wr_owner_nxt;
            wr_beat  <= wr_beat_nxt;
            if (cmd_hs) rr_ptr <= rr_next;
            if (tag_push) tag_wr_ptr <= PtrW'(tag_wr_ptr + 1'b1);
            if (tag_pop) tag_rd_ptr <= PtrW'(tag_rd_ptr + 1'b1);
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= CntW'(tag_cnt + 1'b1);
                2'b01:   tag_cnt <= CntW'(tag_cnt - 1'b1);
                default: tag_cnt <= tag_cnt;
            endcase
            if (rd_hs) rd_beat <= rd_last ? '0 : BeatW'(rd_beat + 1'b1);
            if (ORAMDataOutValid && fifo_empty) ErrorOrphanData <= 1'b1;
        end
    end

    // Tag storage needs no reset; occupancy is tracked by tag_cnt
    always_ff @(posedge Clock) begin
        if (tag_push) tag_mem[tag_wr_ptr] <= grant;
    end

endmodule
